// File: rtl/onehot_decoder_pkg.sv
// Shared definitions for the one-hot encoder/decoder family.
// Holds the vector-width derivation and the ACCUM/HOLD state encoding.
package onehot_decoder_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic int vec_width(input int log_s);
      return 1 << log_s;
   endfunction

endpackage

// File: rtl/onehot_decoder_if.sv
// Index-beat input channel and decoded-vector output channel of the decoder.
// The producer/consumer side uses master; the decoder itself uses slave.
interface onehot_decoder_if
   import onehot_decoder_pkg::*;
#(
   parameter int logS = 4
);
   localparam int S = vec_width(logS);

   logic            in_valid;
   logic            in_ready;
   logic [logS-1:0] in_idx;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [S/2-1:0]  g_output;
   logic [S/2-1:0]  e_output;
   logic            out_dup;

   modport master (
      output in_valid, in_idx, in_last, out_ready,
      input  in_ready, out_valid, g_output, e_output, out_dup
   );

   modport slave (
      input  in_valid, in_idx, in_last, out_ready,
      output in_ready, out_valid, g_output, e_output, out_dup
   );
endinterface

// File: rtl/onehot_decoder_decoder.sv
// Combinational binary-to-one-hot decoder, built by recursively halving the
// index: the MSB selects which half the lower-order one-hot lands in.
module decoder_ #(
   parameter int logS = 4
) (
   input  logic [logS-1:0]      idx,
   output logic [(1<<logS)-1:0] hot
);
   localparam int HALF = 1 << (logS - 1);

   generate
      if (logS == 1) begin : g_leaf
         assign hot = {idx[0], ~idx[0]};
      end else begin : g_split
         logic [HALF-1:0] half;

         decoder_ #(.logS(logS - 1)) u_half (
            .idx (idx[logS-2:0]),
            .hot (half)
         );

         assign hot = idx[logS-1] ? {half, {HALF{1'b0}}} : {{HALF{1'b0}}, half};
      end
   endgenerate
endmodule

// File: rtl/onehot_decoder.sv
// Accumulates a group of index beats into an S-bit vector (OR of 1<<idx) and
// presents it, with a duplicate flag, on a valid/ready output channel.
module onehot_decoder
   import onehot_decoder_pkg::*;
#(
   parameter int logS = 4
) (
   input logic              clk,
   input logic              rst,
   onehot_decoder_if.slave  bus
);
   localparam int S = vec_width(logS);

   state_t         state;
   state_t         state_nxt;
   logic [S-1:0]   acc;
   logic [S-1:0]   out_vec;
   logic [S-1:0]   hot;
   logic           dup_acc;
   logic           dup_reg;
   logic           accept;
   logic           hit;

   decoder_ #(.logS(logS)) u_dec (
      .idx (bus.in_idx),
      .hot (hot)
   );

   assign accept = bus.in_valid && (state == ACCUM);
   assign hit    = |(acc & hot);

   // NOTE: every state reg, including the wide accumulator and output vector, is cleared asynchronously so an abort leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ACCUM;
         acc     <= '0;
         out_vec <= '0;
         dup_acc <= 1'b0;
         dup_reg <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            if (bus.in_last) begin
               out_vec <= acc | hot;
               dup_reg <= dup_acc | hit;
               acc     <= '0;
               dup_acc <= 1'b0;
            end else begin
               acc     <= acc | hot;
               dup_acc <= dup_acc | hit;
            end
         end
      end
   end

   // NOTE: state_nxt gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (accept && bus.in_last) state_nxt = HOLD;
         HOLD:    if (bus.out_ready)         state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Handshake outputs come from state alone; data outputs come from registers.
   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == HOLD);
   assign bus.g_output  = out_vec[S/2-1:0];
   assign bus.e_output  = out_vec[S-1:S/2];
   assign bus.out_dup   = dup_reg;
endmodule

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 Parameter logS, default 4, SHALL set the index width; S = 2**logS is the decoded vector width.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 in_valid  input  1  an index beat is presented.
REQ-005 in_ready  output  1  block accepts an index beat this cycle.
REQ-006 in_idx  input  logS  binary index to decode.
REQ-007 in_last  input  1  beat closes the current group.
REQ-008 out_valid  output  1  decoded group vector available.
REQ-009 out_ready  input  1  consumer accepts the group vector.
REQ-010 g_output  output  S/2  decoded vector bits [S/2-1:0].
REQ-011 e_output  output  S/2  decoded vector bits [S-1:S/2].
REQ-012 out_dup  output  1  some index repeated within the emitted group.

Function
REQ-013 Block SHALL be the inverse of the OR-based encoder: each accepted in_idx k SHALL set bit k of an S-bit accumulator (acc |= 1<<k).
REQ-014 FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 Beat accepted iff in_valid && in_ready; a non-accepted cycle SHALL leave acc unchanged.
REQ-016 Accepted beat with in_last=0 SHALL OR its bit into acc and remain in ACCUM.
REQ-017 Accepted beat with in_last=1 SHALL load the output register with acc|(1<<in_idx), clear acc, and enter HOLD; out_valid SHALL rise the next cycle (1-cycle latency).
REQ-018 Single-beat group (in_last=1 on first beat) SHALL emit exactly one set bit.
REQ-019 In HOLD, g_output/e_output/out_dup SHALL stay stable until out_valid && out_ready; that cycle SHALL return to ACCUM, in_ready high the next cycle.
REQ-020 out_dup SHALL be set if any accepted beat in the group has its bit already set in acc (including the last beat); cleared at group start.
REQ-021 in_idx SHALL be interpreted unsigned; every value 0..S-1 is legal, no wrap or error case.
REQ-022 In ACCUM, g_output/e_output SHALL hold the last emitted vector (all-zero after reset); consumers qualify with out_valid.

Reset
REQ-023 rst high SHALL force state=ACCUM, acc=0, output register=0, out_dup=0, out_valid=0, in_ready=1 after release, immediately regardless of clk.
REQ-024 rst mid-group or in HOLD SHALL discard partial acc and pending output; no vector emitted for the aborted group.

Structure
REQ-025 S derivation and the ACCUM/HOLD state encodings SHALL live in a shared header included by all encoder/decoder blocks.
REQ-026 Binary-to-one-hot SHALL be a combinational sub-module decoder_ (logS-recursive, halving like the encoder), instantiated once.
REQ-027 No combinational path SHALL exist from in_* to out_*; in_ready SHALL depend on state only.

Verification (logS=4)
REQ-028 Single beat idx=3 last=1 -> next cycle out_valid=1, g_output=8'h08, e_output=8'h00, out_dup=0.
REQ-029 Beats 0, 15(last) -> g_output=8'h01, e_output=8'h80, out_dup=0.
REQ-030 Beats 5, 9, 5(last) -> g_output=8'h20, e_output=8'h02, out_dup=1.
REQ-031 Group idx=2 last, out_ready low 3 cycles -> in_ready=0, outputs stable 8'h04/8'h00; out_ready high -> ACCUM, in_ready=1 next cycle.
REQ-032 Beats 1, 7 then rst pulse mid-group, then idx=10 last -> g_output=8'h00, e_output=8'h04, out_dup=0.
REQ-033 Back-to-back groups idx=4 last then idx=12 last with out_ready=1 -> two vectors 8'h10/8'h00 then 8'h00/8'h10, each one cycle after its beat.
